uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Round-robin, packet-locking arbiter that shares the single write port of the uart_tx_top transmit FIFO among NUM_REQ byte-stream requesters, for example the CPU MMIO path, a debug console and boot-ROM messages. A grant is held until the owner's last byte, so messages from different requesters never interleave on uart_tx_o. An idle-timeout releases a requester that stalls mid-packet. Sits directly in front of uart_tx_top and drives its write-enable and write-data inputs.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
TIMEOUT, 1024, grantee-idle cycles before forced release; 0 disables timeout
TO_W, 16, width of the idle counter; must satisfy TIMEOUT < 2**TO_W

Ports:
clk_i  input  1  system clock, all logic on rising edge
rst_i  input  1  synchronous reset, active-high
req_valid_i  input  NUM_REQ  per-requester byte valid
req_data_i  input  NUM_REQ*8  per-requester byte; requester k uses bits [8k+7:8k]
req_last_i  input  NUM_REQ  marks final byte of requester's packet
req_ready_o  output  NUM_REQ  byte accepted when valid&ready in the same cycle
tx_full_i  input  1  from uart_tx_top UART_Durum_Yazmaci_tx_full
tx_wen_o  output  1  to UART_Veri_Yazma_Yazmaci_enable
tx_wdata_o  output  8  to UART_Veri_Yazma_Yazmaci_wdata
grant_o  output  NUM_REQ  one-hot current owner; all-zero when idle
busy_o  output  1  high while in LOCKED
timeout_o  output  1  one-cycle pulse on forced release

Behaviour:
- Reset (rst_i=1 at a clock edge): state=IDLE, grant_o=0, last-served pointer=NUM_REQ-1 (requester 0 wins first), idle counter=0, timeout_o=0. Combinational outputs follow from these values in the same cycle: req_ready_o=0, tx_wen_o=0, busy_o=0. tx_wdata_o is a don't-care when tx_wen_o=0.
- Reset mid-packet: arbiter returns to IDLE and drops the partial packet. No write is issued in the reset cycle.
- State IDLE:
  - req_ready_o=0, tx_wen_o=0.
  - If any req_valid_i is set, select the first valid requester searching ptr+1, ptr+2, … modulo NUM_REQ.
  - Register the winner's one-hot into grant_o and go to LOCKED. Arbitration latency is 1 cycle.
  - No byte is transferred in the IDLE cycle.
- State LOCKED (owner g):
  - req_ready_o[g] = ~tx_full_i. All other ready bits are 0.
  - Transfer condition xfer = req_valid_i[g] & ~tx_full_i.
  - tx_wen_o = xfer, tx_wdata_o = byte g. Both are combinational, with zero latency from the requester to the FIFO. One byte per cycle maximum.
  - xfer & req_last_i[g]: next state IDLE, ptr←g, grant_o←0, counter←0. A new arbitration can win on the following cycle, so back-to-back packets from different requesters have 1 idle cycle between them.
  - xfer & ~last: stay LOCKED, counter←0.
  - ~req_valid_i[g]: counter increments, saturating. When TIMEOUT≠0 and counter reaches TIMEOUT-1 in a cycle where the owner is still not valid:
    - next state is IDLE, ptr←g, grant_o←0, counter←0;
    - timeout_o pulses high for exactly the following cycle.
  - req_valid_i[g] & tx_full_i (backpressure stall): counter holds. The FIFO being full never causes a timeout.
- Fairness: the owner of the just-finished packet has lowest priority in the next arbitration. Each requester waits at most NUM_REQ-1 packets.
- Non-owner valids: ignored and never acknowledged. Requesters must hold data stable while valid&~ready.
- tx_wen_o is never asserted while tx_full_i=1, so the FIFO never overflows by construction.
- busy_o = (state==LOCKED).

Test Plan:
- Single packet: req0 sends 0x48,0x69,0x0A (last on 0x0A), tx_full_i=0 → grant_o=3'b001 one cycle after valid, then tx_wen_o high for 3 consecutive cycles with data 48,69,0A, then IDLE and grant_o=0.
- Contention: req0 and req2 both valid from reset with 2-byte packets → req0 packet completes fully, 1 idle cycle follows, then req2 packet. Re-raising req0 immediately after yields order req2 then req0 (no starvation).
- Backpressure: tx_full_i high for 10 cycles in the middle of a req1 packet → req_ready_o[1]=0 and tx_wen_o=0 throughout the stall, no byte is lost or duplicated, and timeout_o stays 0.
- Timeout: TIMEOUT=16; req1 sends 1 non-last byte, then drops valid → after 16 idle cycles the arbiter returns to IDLE, timeout_o pulses once, and a pending req2 is granted next.
- Reset mid-packet: assert rst_i for 1 cycle after the 2nd byte of a 4-byte req0 packet → grant_o=0, busy_o=0 and tx_wen_o=0 at the next edge. The next arbitration with req0 and req1 both valid grants req0.
- Boundary with NUM_REQ=2 and TIMEOUT=0: a requester is held idle for 5000 cycles → no release and timeout_o never asserts.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin, packet-locking arbiter sharing the uart_tx_top FIFO
//            write port among NUM_REQ byte-stream requesters, with idle timeout.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ*8-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  input  logic                 tx_full_i,
  output logic                 tx_wen_o,
  output logic [7:0]           tx_wdata_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o,
  output logic                 timeout_o
);

  localparam int                   c_PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [c_PTR_W-1:0]   c_PTR_RST = c_PTR_W'(NUM_REQ - 1);
  localparam logic [TO_W-1:0]      c_TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]      c_CNT_MAX = '1;
  localparam logic [NUM_REQ-1:0]   c_ONE     = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t             r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [c_PTR_W-1:0] r_ptr;
  logic [c_PTR_W-1:0] r_owner;
  logic [TO_W-1:0]    r_cnt;
  logic               r_timeout;

  logic               w_locked;
  logic               w_xfer;
  logic               w_found;
  logic [c_PTR_W-1:0] w_win_idx;

  // Rotating search starting just after the last-served requester.
  always_comb begin
    w_found   = 1'b0;
    w_win_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      int idx;
      idx = (int'(r_ptr) + i) % NUM_REQ;
      if (!w_found && req_valid_i[idx]) begin
        w_found   = 1'b1;
        w_win_idx = c_PTR_W'(idx);
      end
    end
  end

  // Write path is combinational; a reset cycle never issues a write.
  assign w_locked    = (r_state == ST_LOCKED);
  assign w_xfer      = w_locked & req_valid_i[r_owner] & ~tx_full_i & ~rst_i;
  assign tx_wen_o    = w_xfer;
  assign tx_wdata_o  = req_data_i[{r_owner, 3'b000} +: 8];
  assign req_ready_o = (w_locked && !tx_full_i && !rst_i) ? r_grant : '0;
  assign grant_o     = r_grant;
  assign busy_o      = w_locked;
  assign timeout_o   = r_timeout;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_ptr     <= c_PTR_RST;
      r_owner   <= '0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_found) begin
            r_state <= ST_LOCKED;
            r_owner <= w_win_idx;
            r_grant <= c_ONE << w_win_idx;
          end
        end
        ST_LOCKED: begin
          if (w_xfer) begin
            r_cnt <= '0;
            if (req_last_i[r_owner]) begin
              r_state <= ST_IDLE;
              r_ptr   <= r_owner;
              r_grant <= '0;
            end
          end else if (!req_valid_i[r_owner]) begin
            if ((TIMEOUT != 0) && (r_cnt == c_TO_LAST)) begin
              r_state   <= ST_IDLE;
              r_ptr     <= r_owner;
              r_grant   <= '0;
              r_cnt     <= '0;
              r_timeout <= 1'b1;
            end else if (r_cnt != c_CNT_MAX) begin
              r_cnt <= r_cnt + TO_W'(1);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Directed + randomized bench with a packet-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int N  = 3;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  valid, last, ready;
  logic [N*8-1:0] data;
  logic          full, wen, busy, tout;
  logic [7:0]    wdata;
  logic [N-1:0]  grant;

  logic          rst_b;
  logic [1:0]    valid_b, last_b, ready_b, grant_b;
  logic [15:0]   data_b;
  logic          full_b, wen_b, busy_b, tout_b;
  logic [7:0]    wdata_b;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT(TO), .TO_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_data_i(data),
    .req_last_i(last), .req_ready_o(ready), .tx_full_i(full), .tx_wen_o(wen),
    .tx_wdata_o(wdata), .grant_o(grant), .busy_o(busy), .timeout_o(tout)
  );

  uart_tx_arbiter #(.NUM_REQ(2), .TIMEOUT(0), .TO_W(8)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .req_valid_i(valid_b), .req_data_i(data_b),
    .req_last_i(last_b), .req_ready_o(ready_b), .tx_full_i(full_b), .tx_wen_o(wen_b),
    .tx_wdata_o(wdata_b), .grant_o(grant_b), .busy_o(busy_b), .timeout_o(tout_b)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: packet owner (-1 when idle), last served requester,
  // idle cycles of the owner since its last transfer, pending timeout pulse.
  bit           chk_en = 1'b0;
  int           m_owner = -1;
  int           m_last  = N - 1;
  int           m_idle  = 0;
  bit           m_to    = 1'b0;
  logic [N-1:0] acc     = '0;

  always @(negedge clk) begin : model
    logic [N-1:0] e_grant, e_ready;
    bit e_busy, e_xfer, own_valid;
    if (chk_en) begin
      e_busy    = (m_owner >= 0);
      own_valid = e_busy ? valid[m_owner] : 1'b0;
      e_grant   = e_busy ? N'(1 << m_owner) : '0;
      e_xfer    = e_busy && !rst && own_valid && !full;
      e_ready   = (e_busy && !rst && !full) ? e_grant : '0;
      chk("grant", 32'(grant), 32'(e_grant));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("ready", 32'(ready), 32'(e_ready));
      chk("wen", 32'(wen), 32'(e_xfer));
      chk("timeout", 32'(tout), 32'(m_to));
      if (e_xfer) chk("wdata", 32'(wdata), 32'(data[8*m_owner +: 8]));
      acc  = e_xfer ? e_grant : '0;
      m_to = 1'b0;
      if (rst) begin
        m_owner = -1; m_last = N - 1; m_idle = 0;
      end else if (!e_busy) begin
        for (int i = 1; i <= N; i++) begin
          if (m_owner < 0 && valid[(m_last + i) % N]) begin
            m_owner = (m_last + i) % N;
            m_idle  = 0;
          end
        end
      end else if (e_xfer) begin
        m_idle = 0;
        if (last[m_owner]) begin m_last = m_owner; m_owner = -1; end
      end else if (!own_valid) begin
        m_idle++;
        if (m_idle == TO) begin
          m_last = m_owner; m_owner = -1; m_idle = 0; m_to = 1'b1;
        end
      end
    end
  end

  // One cycle for dut: inputs change 1 time unit after the edge, sampling at negedge.
  task automatic step(input logic [N-1:0] v, input logic [23:0] d, input logic [N-1:0] l,
                      input logic f, input logic r);
    @(posedge clk); #1;
    valid = v; data = d; last = l; full = f; rst = r;
    @(negedge clk);
  endtask

  task automatic stepb(input logic [1:0] v, input logic [15:0] d, input logic [1:0] l,
                       input logic r);
    @(posedge clk); #1;
    valid_b = v; data_b = d; last_b = l; rst_b = r;
    @(negedge clk);
  endtask

  initial begin
    int first_to, n_to;
    int hold_left [N];
    logic [N-1:0] pend;
    int bad;
    rst = 1'b1; valid = '0; data = '0; last = '0; full = 1'b0;
    rst_b = 1'b1; valid_b = '0; data_b = '0; last_b = '0; full_b = 1'b0;

    step('0, '0, '0, 0, 1);
    step('0, '0, '0, 0, 1);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wen", 32'(wen), 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_timeout", 32'(tout), 0);
    chk_en = 1'b1;

    // Single packet from requester 0.
    step(3'b001, 24'h000048, 3'b000, 0, 0);
    chk("sp_idle_grant", 32'(grant), 0);
    chk("sp_idle_wen", 32'(wen), 0);
    step(3'b001, 24'h000048, 3'b000, 0, 0);
    chk("sp_grant", 32'(grant), 3'b001);
    chk("sp_b0", 32'({wen, wdata}), 32'h148);
    step(3'b001, 24'h000069, 3'b000, 0, 0);
    chk("sp_b1", 32'({wen, wdata}), 32'h169);
    step(3'b001, 24'h00000A, 3'b001, 0, 0);
    chk("sp_b2", 32'({wen, wdata}), 32'h10A);
    step(3'b000, 24'h0, 3'b000, 0, 0);
    chk("sp_end_grant", 32'(grant), 0);

    // Contention between requesters 0 and 2, then 0 re-raised.
    step(3'b000, 24'h0, 3'b000, 0, 1);
    step(3'b101, 24'hC000A0, 3'b000, 0, 0);
    step(3'b101, 24'hC000A0, 3'b000, 0, 0);
    chk("ct_grant0", 32'(grant), 3'b001);
    step(3'b101, 24'hC000A1, 3'b001, 0, 0);
    chk("ct_a1", 32'({wen, wdata}), 32'h1A1);
    step(3'b101, 24'hC000B0, 3'b000, 0, 0);
    chk("ct_gap_wen", 32'(wen), 0);
    step(3'b101, 24'hC000B0, 3'b000, 0, 0);
    chk("ct_grant2", 32'(grant), 3'b100);
    chk("ct_c0", 32'(wdata), 32'hC0);
    step(3'b101, 24'hC100B0, 3'b101, 0, 0);
    step(3'b001, 24'h0000B0, 3'b001, 0, 0);
    step(3'b001, 24'h0000B0, 3'b001, 0, 0);
    chk("ct_grant0_again", 32'(grant), 3'b001);
    chk("ct_b0", 32'({wen, wdata}), 32'h1B0);

    // Backpressure in the middle of a requester 1 packet.
    step(3'b010, 24'h001100, 3'b000, 0, 0);
    step(3'b010, 24'h001100, 3'b000, 0, 0);
    chk("bp_b0", 32'({wen, wdata}), 32'h111);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      step(3'b010, 24'h002200, 3'b000, 1, 0);
      if (ready[1] !== 1'b0 || wen !== 1'b0 || tout !== 1'b0 || busy !== 1'b1) bad++;
    end
    chk("bp_stall_cycles_bad", 32'(bad), 0);
    step(3'b010, 24'h002200, 3'b000, 0, 0);
    chk("bp_b1", 32'({wen, wdata}), 32'h122);
    step(3'b010, 24'h003300, 3'b010, 0, 0);
    chk("bp_b2", 32'({wen, wdata}), 32'h133);

    // Timeout: requester 1 stalls after one byte, requester 2 waits.
    step(3'b010, 24'h005A00, 3'b000, 0, 0);
    step(3'b010, 24'h005A00, 3'b000, 0, 0);
    chk("to_xfer", 32'({wen, wdata}), 32'h15A);
    first_to = -1; n_to = 0;
    for (int k = 1; k <= 20; k++) begin
      step(3'b100, 24'h770000, 3'b000, 0, 0);
      if (tout === 1'b1) begin n_to++; if (first_to < 0) first_to = k; end
      if (k == 18) chk("to_grant2", 32'(grant), 3'b100);
    end
    chk("to_cycle", 32'(first_to), 17);
    chk("to_pulses", 32'(n_to), 1);
    step(3'b100, 24'h780000, 3'b100, 0, 0);
    step(3'b000, 24'h0, 3'b000, 0, 0);

    // Reset after the 2nd byte of a 4-byte requester 0 packet.
    step(3'b001, 24'h000001, 3'b000, 0, 0);
    step(3'b001, 24'h000001, 3'b000, 0, 0);
    step(3'b001, 24'h000002, 3'b000, 0, 0);
    step(3'b001, 24'h000003, 3'b000, 0, 1);
    chk("rm_rst_wen", 32'(wen), 0);
    step(3'b011, 24'h001103, 3'b000, 0, 0);
    chk("rm_grant", 32'(grant), 0);
    chk("rm_busy", 32'(busy), 0);
    chk("rm_wen", 32'(wen), 0);
    step(3'b011, 24'h001103, 3'b000, 0, 0);
    chk("rm_rearb", 32'(grant), 3'b001);
    step(3'b010, 24'h001104, 3'b001, 0, 0);

    // Randomized traffic; data and last stay put while a byte is pending.
    for (int k = 0; k < N; k++) hold_left[k] = 0;
    pend = '0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
        if (acc[k]) pend[k] = 1'b0;
        if (pend[k] && $urandom_range(99) >= 5) begin
          valid[k] = 1'b1;
        end else if (hold_left[k] > 0) begin
          hold_left[k]--;
          valid[k] = 1'b0;
          pend[k]  = 1'b0;
        end else begin
          if ($urandom_range(99) < 3) hold_left[k] = $urandom_range(25, 10);
          valid[k]       = ($urandom_range(99) < 70);
          pend[k]        = valid[k];
          data[8*k +: 8] = 8'($urandom);
          last[k]        = ($urandom_range(3) == 0);
        end
      end
      full = ($urandom_range(99) < 25);
      rst  = ($urandom_range(999) < 3);
      @(negedge clk);
    end
    step('0, '0, '0, 0, 0);

    // Two requesters, timeout disabled: long owner stall must never release.
    stepb(2'b00, 16'h0, 2'b00, 1);
    stepb(2'b01, 16'h0077, 2'b00, 0);
    stepb(2'b01, 16'h0077, 2'b00, 0);
    chk("b_first", 32'({grant_b, wen_b, wdata_b}), 32'h177 | (32'h1 << 9));
    bad = 0;
    for (int k = 0; k < 5000; k++) begin
      stepb(2'b10, 16'h9900, 2'b00, 0);
      if (busy_b !== 1'b1 || tout_b !== 1'b0 || grant_b !== 2'b01 || wen_b !== 1'b0) bad++;
    end
    chk("b_long_stall_bad", 32'(bad), 0);
    stepb(2'b01, 16'h0078, 2'b01, 0);
    chk("b_last", 32'({wen_b, wdata_b}), 32'h178);
    stepb(2'b00, 16'h0, 2'b00, 0);
    chk("b_release", 32'({busy_b, grant_b}), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
